// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared widths, FSM encodings and requester IDs for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam int VIRT_ADDR_WIDTH   = 32;
    localparam int ICACHE_LINE_WIDTH = 128;
    localparam int DEFAULT_TIMEOUT   = 64;
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_DELIVER = 2'd3;
    localparam logic OWNER_IC = 1'b0;
    localparam logic OWNER_DC = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker with a registered last-grant pointer
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_ic,
    input  logic req_dc,
    input  logic update,
    input  logic upd_owner,
    output logic valid,
    output logic grant
);
    logic last;
    // last-grant pointer starts at dcache so the first tie goes to icache
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last <= OWNER_DC;
        else if (update) last <= upd_owner;
    end
    // on a tie pick the requester not granted last, otherwise whoever asks
    always_comb begin
        valid = req_ic | req_dc;
        grant = (req_ic & req_dc) ? ~last : req_dc;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one line-wide memory port between icache fills and dcache fills/writebacks
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = VIRT_ADDR_WIDTH,
    parameter int LINE_W  = ICACHE_LINE_WIDTH,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_rdy,
    output logic [LINE_W-1:0] ic_line,
    input  logic              ic_filled_ack,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_rdy,
    output logic [LINE_W-1:0] dc_line,
    input  logic              dc_filled_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_data_rdy,
    output logic              owner,
    output logic              busy,
    output logic              timeout_err
);
    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = {ADDR_W{1'b1}} << OFF_W;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             arb_valid;
    logic             arb_grant;
    logic             done;
    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_ic    (ic_req),
        .req_dc    (dc_req),
        .update    (done),
        .upd_owner (owner),
        .valid     (arb_valid),
        .grant     (arb_grant)
    );
    // strobes and handshake outputs decoded from the state and current owner
    always_comb begin
        done    = (state == S_DELIVER) && (owner ? dc_filled_ack : ic_filled_ack);
        mem_req = state == S_ISSUE;
        busy    = state != S_IDLE;
        ic_rdy  = (state == S_DELIVER) && (owner == OWNER_IC);
        dc_rdy  = (state == S_DELIVER) && (owner == OWNER_DC);
    end
    // request latching, watchdog reissue and line capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            owner       <= OWNER_IC;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            ic_line     <= '0;
            dc_line     <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (arb_valid) begin
                    owner     <= arb_grant;
                    mem_we    <= arb_grant & dc_we;
                    mem_addr  <= (arb_grant ? dc_addr : ic_addr) & ADDR_MASK;
                    mem_wdata <= arb_grant ? dc_wdata : '0;
                    state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: if (mem_data_rdy) begin
                    cnt   <= '0;
                    state <= S_DELIVER;
                    if (!mem_we && owner == OWNER_DC) dc_line <= mem_rdata;
                    if (!mem_we && owner == OWNER_IC) ic_line <= mem_rdata;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    cnt         <= '0;
                    timeout_err <= 1'b1;
                    state       <= S_ISSUE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: if (done) state <= S_IDLE;
            endcase
        end
    end
endmodule
